// File: rtl/pipe_run_ctrl.sv
// rtl/pipe_run_ctrl.sv - debug run/step/breakpoint controller for the pipeline
// Gates the pipeline enable from debug commands and a single PC breakpoint.
module pipe_run_ctrl #(
  parameter int STEP_W = 16
) (
  input  logic        clk_cpu,
  input  logic        rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_arg,
  input  logic [31:0] pc,
  input  logic        pcsrc,
  output logic        cpu_en,
  output logic        flush,
  output logic        halted,
  output logic        bp_hit,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_t;

  localparam logic [1:0] OP_STOP   = 2'b00;
  localparam logic [1:0] OP_RUN    = 2'b01;
  localparam logic [1:0] OP_STEP   = 2'b10;
  localparam logic [1:0] OP_SET_BP = 2'b11;

  state_t            state, state_nxt;
  logic [STEP_W-1:0] step_cnt, step_cnt_nxt;
  logic [STEP_W-1:0] step_n;
  logic [31:0]       bp_addr;
  logic              bp_valid;
  logic              bp_skip, bp_skip_nxt;
  logic              bp_hit_nxt;
  logic              flush_pend;
  logic              accept;
  logic              match;

  assign cmd_ready = (state != S_STEP) || (cmd_op == OP_STOP);
  assign accept    = cmd_valid & cmd_ready;
  assign step_n    = cmd_arg[STEP_W-1:0];
  assign match     = bp_valid & (pc == bp_addr) & ~bp_skip;
  assign cpu_en    = (state != S_HALT) & ~match;
  assign flush     = cpu_en & (pcsrc | flush_pend);
  assign halted    = (state == S_HALT);

  always_ff @(posedge clk_cpu or negedge rstn) begin
    if (!rstn) begin
      state    <= S_HALT;
      step_cnt <= '0;
      bp_hit   <= 1'b0;
      bp_skip  <= 1'b0;
    end else begin
      state    <= state_nxt;
      step_cnt <= step_cnt_nxt;
      bp_hit   <= bp_hit_nxt;
      bp_skip  <= bp_skip_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    step_cnt_nxt = step_cnt;
    bp_hit_nxt   = bp_hit;
    bp_skip_nxt  = bp_skip;
    if (cpu_en) bp_skip_nxt = 1'b0;
    case (state)
      S_HALT: begin
        if (accept && cmd_op == OP_RUN) begin
          state_nxt   = S_RUN;
          bp_hit_nxt  = 1'b0;
          bp_skip_nxt = 1'b1;
        end else if (accept && cmd_op == OP_STEP && step_n != '0) begin
          state_nxt    = S_STEP;
          step_cnt_nxt = step_n;
          bp_hit_nxt   = 1'b0;
          bp_skip_nxt  = 1'b1;
        end
      end
      S_RUN: begin
        if (accept && cmd_op == OP_STOP) begin
          state_nxt    = S_HALT;
          step_cnt_nxt = '0;
        end else if (accept && cmd_op == OP_STEP) begin
          if (step_n == '0) begin
            state_nxt    = S_HALT;
            step_cnt_nxt = '0;
          end else begin
            state_nxt    = S_STEP;
            step_cnt_nxt = step_n;
            bp_skip_nxt  = 1'b1;
          end
        end
      end
      S_STEP: begin
        if (accept && cmd_op == OP_STOP) begin
          state_nxt    = S_HALT;
          step_cnt_nxt = '0;
        end else if (cpu_en) begin
          if (step_cnt == STEP_W'(1)) begin
            state_nxt    = S_HALT;
            step_cnt_nxt = '0;
          end else begin
            step_cnt_nxt = step_cnt - STEP_W'(1);
          end
        end
      end
      default: state_nxt = S_HALT;
    endcase
    // A breakpoint stall outranks every command and the last step.
    if (match && state != S_HALT) begin
      state_nxt    = S_HALT;
      step_cnt_nxt = '0;
      bp_hit_nxt   = 1'b1;
      bp_skip_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk_cpu or negedge rstn) begin
    if (!rstn) begin
      bp_addr  <= '0;
      bp_valid <= 1'b0;
    end else if (accept && cmd_op == OP_SET_BP) begin
      if (cmd_arg[1:0] == 2'b00) begin
        bp_addr  <= cmd_arg;
        bp_valid <= 1'b1;
      end else begin
        bp_valid <= 1'b0;
      end
    end
  end

  // Pending branch flush survives halted cycles until the next enabled cycle.
  always_ff @(posedge clk_cpu or negedge rstn) begin
    if (!rstn) begin
      flush_pend <= 1'b0;
      retired    <= '0;
    end else if (cpu_en) begin
      flush_pend <= pcsrc;
      retired    <= retired + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// tb/tb_pipe_run_ctrl.sv - directed self-checking bench for pipe_run_ctrl
module tb_pipe_run_ctrl;

  localparam logic [1:0] OP_STOP   = 2'b00;
  localparam logic [1:0] OP_RUN    = 2'b01;
  localparam logic [1:0] OP_STEP   = 2'b10;
  localparam logic [1:0] OP_SET_BP = 2'b11;

  logic        clk_cpu = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = OP_STOP;
  logic [31:0] cmd_arg = '0;
  logic [31:0] pc = '0;
  logic        pcsrc = 1'b0;
  logic        cpu_en, flush, halted, bp_hit;
  logic [31:0] retired;

  int errors = 0;
  int checks = 0;
  int en_cnt;

  pipe_run_ctrl #(.STEP_W(16)) dut (
    .clk_cpu(clk_cpu), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .pc(pc), .pcsrc(pcsrc),
    .cpu_en(cpu_en), .flush(flush), .halted(halted), .bp_hit(bp_hit), .retired(retired)
  );

  always #5 clk_cpu = ~clk_cpu;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_cpu);
    #1;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [31:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    tick();
    cmd_valid = 1'b0;
    #1;
  endtask

  initial begin
    #2;
    check("rst_halted", {31'd0, halted}, 32'd1);
    check("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_bp_hit", {31'd0, bp_hit}, 32'd0);
    check("rst_retired", retired, 32'd0);
    tick();
    rstn = 1'b1;
    pc = 32'h100;

    cmd(OP_RUN, 32'd0);
    check("run_cpu_en", {31'd0, cpu_en}, 32'd1);
    check("run_halted", {31'd0, halted}, 32'd0);
    check("run_retired0", retired, 32'd0);
    repeat (4) tick();
    check("run_retired4", retired, 32'd4);
    cmd(OP_STOP, 32'd0);
    check("stop_retired", retired, 32'd5);
    check("stop_halted", {31'd0, halted}, 32'd1);
    check("stop_cpu_en", {31'd0, cpu_en}, 32'd0);

    cmd(OP_STEP, 32'd5);
    cmd_op = OP_RUN;
    #1;
    check("step_ready_run", {31'd0, cmd_ready}, 32'd0);
    cmd_op = OP_STOP;
    #1;
    check("step_ready_stop", {31'd0, cmd_ready}, 32'd1);
    cmd_op = OP_RUN;
    en_cnt = 0;
    repeat (10) begin
      if (cpu_en) en_cnt++;
      tick();
    end
    check("step5_en_cycles", en_cnt, 32'd5);
    check("step5_halted", {31'd0, halted}, 32'd1);
    check("step5_retired", retired, 32'd10);
    cmd(OP_STEP, 32'd0);
    check("step0_cpu_en", {31'd0, cpu_en}, 32'd0);
    tick();
    check("step0_halted", {31'd0, halted}, 32'd1);
    check("step0_retired", retired, 32'd10);

    pc = 32'h3C;
    cmd(OP_SET_BP, 32'h40);
    cmd(OP_RUN, 32'd0);
    check("bp_pre_en", {31'd0, cpu_en}, 32'd1);
    tick();
    pc = 32'h40;
    #1;
    check("bp_stall", {31'd0, cpu_en}, 32'd0);
    tick();
    check("bp_halted", {31'd0, halted}, 32'd1);
    check("bp_hit_set", {31'd0, bp_hit}, 32'd1);
    check("bp_retired", retired, 32'd11);
    cmd(OP_RUN, 32'd0);
    check("bp_skip_en", {31'd0, cpu_en}, 32'd1);
    check("bp_hit_clr", {31'd0, bp_hit}, 32'd0);
    pc = 32'h44;
    tick();
    check("bp_leave_ret", retired, 32'd12);
    cmd(OP_STOP, 32'd0);

    cmd(OP_RUN, 32'd0);
    pcsrc = 1'b1;
    #1;
    check("flush_branch", {31'd0, flush}, 32'd1);
    tick();
    pcsrc = 1'b0;
    #1;
    check("flush_next", {31'd0, flush}, 32'd1);
    tick();
    check("flush_done", {31'd0, flush}, 32'd0);
    pcsrc = 1'b1;
    cmd_valid = 1'b1;
    cmd_op = OP_STOP;
    #1;
    check("flush_stop_cyc", {31'd0, flush}, 32'd1);
    tick();
    pcsrc = 1'b0;
    cmd_valid = 1'b0;
    #1;
    check("flush_halt_hlt", {31'd0, halted}, 32'd1);
    check("flush_halt_off", {31'd0, flush}, 32'd0);
    tick();
    cmd(OP_RUN, 32'd0);
    check("flush_resume", {31'd0, flush}, 32'd1);
    tick();
    check("flush_resume_clr", {31'd0, flush}, 32'd0);
    cmd(OP_STOP, 32'd0);
    check("flush_retired", retired, 32'd18);

    cmd(OP_SET_BP, 32'h80);
    pc = 32'h70;
    cmd(OP_STEP, 32'd3);
    tick();
    pc = 32'h74;
    tick();
    pc = 32'h80;
    #1;
    check("stepbp_stall", {31'd0, cpu_en}, 32'd0);
    tick();
    check("stepbp_halted", {31'd0, halted}, 32'd1);
    check("stepbp_hit", {31'd0, bp_hit}, 32'd1);
    check("stepbp_retired", retired, 32'd20);
    cmd(OP_SET_BP, 32'h41);
    cmd(OP_RUN, 32'd0);
    pc = 32'h41;
    #1;
    check("bpoff_en", {31'd0, cpu_en}, 32'd1);
    check("bpoff_hit", {31'd0, bp_hit}, 32'd0);
    tick();
    pc = 32'h80;
    tick();
    check("bpoff_running", {31'd0, halted}, 32'd0);
    cmd(OP_STOP, 32'd0);
    check("bpoff_retired", retired, 32'd23);

    cmd(OP_RUN, 32'd0);
    cmd(OP_STEP, 32'd2);
    check("runstep_active", {31'd0, halted}, 32'd0);
    tick();
    tick();
    check("runstep_halted", {31'd0, halted}, 32'd1);
    check("runstep_retired", retired, 32'd26);
    cmd(OP_RUN, 32'd0);
    cmd(OP_STEP, 32'd0);
    check("runstep0_halted", {31'd0, halted}, 32'd1);
    tick();
    check("runstep0_ret", retired, 32'd27);

    force dut.retired = 32'hFFFF_FFFF;
    #1;
    release dut.retired;
    #1;
    check("wrap_preload", retired, 32'hFFFF_FFFF);
    cmd(OP_STEP, 32'd1);
    tick();
    check("wrap_zero", retired, 32'd0);
    check("wrap_halted", {31'd0, halted}, 32'd1);

    cmd(OP_SET_BP, 32'h200);
    pc = 32'h300;
    cmd(OP_STEP, 32'd100);
    tick();
    tick();
    pcsrc = 1'b1;
    tick();
    pcsrc = 1'b0;
    cmd_valid = 1'b1;
    cmd_op = OP_RUN;
    #2;
    check("midstep_ready", {31'd0, cmd_ready}, 32'd0);
    rstn = 1'b0;
    #1;
    check("mrst_halted", {31'd0, halted}, 32'd1);
    check("mrst_cpu_en", {31'd0, cpu_en}, 32'd0);
    check("mrst_flush", {31'd0, flush}, 32'd0);
    check("mrst_ready", {31'd0, cmd_ready}, 32'd1);
    check("mrst_bp_hit", {31'd0, bp_hit}, 32'd0);
    check("mrst_retired", retired, 32'd0);
    tick();
    cmd_valid = 1'b0;
    rstn = 1'b1;
    tick();
    check("post_rst_halted", {31'd0, halted}, 32'd1);
    pc = 32'h200;
    cmd(OP_RUN, 32'd0);
    check("post_rst_en", {31'd0, cpu_en}, 32'd1);
    check("post_rst_flush", {31'd0, flush}, 32'd0);
    tick();
    check("post_rst_bpclr", {31'd0, cpu_en}, 32'd1);
    check("post_rst_ret", retired, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_run_ctrl.md
PIPE_RUN_CTRL -- requirements
Module: pipe_run_ctrl

Interface
REQ-001 SHALL have parameter STEP_W, default 16, width of the step counter (step count is taken from cmd_arg[STEP_W-1:0]).
REQ-002 SHALL have port clk_cpu  input  1  pipeline clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cmd_valid  input  1  debug command present.
REQ-005 SHALL have port cmd_ready  output  1  command accepted this cycle when cmd_valid & cmd_ready.
REQ-006 SHALL have port cmd_op  input  2  00 STOP, 01 RUN, 10 STEP, 11 SET_BP.
REQ-007 SHALL have port cmd_arg  input  32  step count (STEP) or breakpoint address (SET_BP).
REQ-008 SHALL have port pc  input  32  current IF-stage PC.
REQ-009 SHALL have port pcsrc  input  1  branch-taken from EX stage.
REQ-010 SHALL have port cpu_en  output  1  pipeline register / PC write enable.
REQ-011 SHALL have port flush  output  1  clear IF/ID and ID/EX contents this cycle.
REQ-012 SHALL have port halted  output  1  high in state HALT.
REQ-013 SHALL have port bp_hit  output  1  sticky breakpoint-hit flag.
REQ-014 SHALL have port retired  output  32  count of cpu_en cycles.

Function
REQ-015 SHALL implement a 3-state FSM: HALT, RUN, STEP; halted = (state==HALT).
REQ-016 cmd_ready SHALL be combinational: 1 when state!=STEP, or when cmd_op==STOP.
REQ-017 match SHALL be bp_valid & (pc==bp_addr) & ~bp_skip; cpu_en SHALL be (state==RUN | state==STEP) & ~match.
REQ-018 On match in RUN or STEP: next state HALT, bp_hit<=1, step_cnt<=0; the matching instruction is not fetched past.
REQ-019 bp_skip SHALL be set on acceptance of RUN or STEP, and cleared on the first cycle with cpu_en=1.
REQ-020 RUN accepted in HALT: next state RUN, bp_hit<=0; RUN accepted in RUN: no effect.
REQ-021 STEP accepted in HALT with N=cmd_arg[STEP_W-1:0]: N==0 is a no-op (stays HALT, bp_hit unchanged); N>0 -> state STEP, step_cnt<=N, bp_hit<=0.
REQ-022 STEP accepted in RUN: next state STEP with step_cnt<=N; N==0 -> HALT.
REQ-023 In STEP, each cpu_en cycle SHALL decrement step_cnt; when step_cnt==1 on a cpu_en cycle, next state HALT; exactly N cpu_en cycles per step command absent breakpoint/STOP.
REQ-024 STOP accepted in RUN or STEP: next state HALT, step_cnt<=0; cpu_en follows REQ-017 in the accepting cycle; STOP in HALT: no effect.
REQ-025 SET_BP accepted: if cmd_arg[1:0]==00, bp_addr<=cmd_arg and bp_valid<=1; otherwise bp_valid<=0; state unchanged.
REQ-026 flush SHALL be cpu_en & (pcsrc | flush_pend); flush_pend SHALL be set on a cpu_en cycle with pcsrc and cleared on the next cpu_en cycle without pcsrc, holding across halted cycles.
REQ-027 retired SHALL increment by 1 on every cpu_en cycle, wrapping 0xFFFFFFFF -> 0.
REQ-028 Simultaneous: breakpoint match has priority over STOP and over the final step; bp_hit is set in both cases.

Reset
REQ-029 While rstn low: state HALT, cpu_en 0, flush 0, halted 1, cmd_ready 1, bp_hit 0, bp_valid 0, bp_addr 0, bp_skip 0, flush_pend 0, step_cnt 0, retired 0.
REQ-030 Reset asserted mid-RUN or mid-STEP SHALL abort immediately to REQ-029 values; no pending command survives.

Verification
REQ-031 Reset release, RUN -> cpu_en 1 from next cycle; retired increments by 1 per cycle; halted 0.
REQ-032 STEP arg 5 from HALT -> exactly 5 cpu_en cycles, then halted 1, retired +5; STEP arg 0 -> no cpu_en, stays HALT.
REQ-033 SET_BP 0x40, RUN, pc reaches 0x40 -> cpu_en 0 that cycle, HALT, bp_hit 1; RUN again -> bp_skip lets pc leave 0x40, bp_hit 0.
REQ-034 pcsrc 1 on one enabled cycle in RUN -> flush 1 on that and the next enabled cycle; STOP between them -> second flush delivered on first cycle after resume.
REQ-035 STEP 3 with breakpoint matching on third step -> HALT with bp_hit 1, retired +2; SET_BP 0x41 -> bp_valid cleared, no further halts.
REQ-036 Preload retired to 0xFFFFFFFF via run cycles (or force), one enabled cycle -> retired 0; rstn low mid-STEP -> all REQ-029 values.
